// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: owns the PC, buffers cache hits in a small FIFO toward decode.
// Optional FETCH_PERF_EN macro enables the push and miss-cycle performance counters.
module inst_fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH    = 2,
  parameter int unsigned MISS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] cache_addr,
  input  logic [31:0] cache_data,
  input  logic        cache_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        miss_err,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_miss_cycles
);

  localparam int unsigned AW = $clog2(BUF_DEPTH);
  localparam logic [15:0] TMO = 16'(MISS_TIMEOUT);

  typedef enum logic [1:0] {FETCH, MISS, STALL} state_t;

  state_t      state, state_n;
  logic [31:0] pc;
  logic [15:0] miss_cnt, cnt_n;
  logic        err_set;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [31:0] inst_mem [BUF_DEPTH];
  logic [31:0] pc_mem   [BUF_DEPTH];
  logic        empty, full, pop, space, push;
  logic        unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign out_valid  = !empty;
  assign out_inst   = inst_mem[rd_ptr[AW-1:0]];
  assign out_pc     = pc_mem[rd_ptr[AW-1:0]];
  assign cache_addr = pc;

  // Space counts a same-cycle pop, so a full FIFO can push and pop together.
  assign pop   = out_valid && out_ready && !redirect_valid;
  assign space = !full || (out_valid && out_ready);
  assign push  = !redirect_valid && cache_ready && space;

  always_comb begin
    state_n = state;
    cnt_n   = miss_cnt;
    if (redirect_valid) begin
      state_n = FETCH;
      cnt_n   = '0;
    end else if (state == MISS) begin
      if (cache_ready) begin
        state_n = space ? FETCH : STALL;
        cnt_n   = '0;
      end else begin
        cnt_n = (miss_cnt >= TMO) ? TMO : miss_cnt + 16'd1;
      end
    end else if (state == FETCH || space) begin
      // STALL with space frees up and behaves exactly like FETCH.
      if (!cache_ready) begin
        state_n = MISS;
        cnt_n   = 16'd1;
      end else begin
        state_n = space ? FETCH : STALL;
      end
    end
    err_set = (state_n == MISS) && (cnt_n == TMO);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC;
      state    <= FETCH;
      miss_cnt <= '0;
      miss_err <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inst_mem <= '{default: '0};
      pc_mem   <= '{default: '0};
    end else begin
      state    <= state_n;
      miss_cnt <= cnt_n;
      if (err_set) miss_err <= 1'b1;
      if (redirect_valid) begin
        pc     <= {redirect_pc[31:2], 2'b00};
        rd_ptr <= wr_ptr;
      end else begin
        if (push) begin
          inst_mem[wr_ptr[AW-1:0]] <= cache_data;
          pc_mem[wr_ptr[AW-1:0]]   <= pc;
          wr_ptr                   <= wr_ptr + (AW+1)'(1);
          pc                       <= pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, miss_cyc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetched_q  <= '0;
      miss_cyc_q <= '0;
    end else begin
      if (push) fetched_q <= fetched_q + 32'd1;
      if (state == MISS) miss_cyc_q <= miss_cyc_q + 32'd1;
    end
  end

  assign perf_fetched     = fetched_q;
  assign perf_miss_cycles = miss_cyc_q;
`else
  assign perf_fetched     = '0;
  assign perf_miss_cycles = '0;
`endif

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Directed bench for inst_fetch_stage: scoreboard queue of expected {inst, pc} plus direct checks.
module tb_inst_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] cache_addr;
  logic [31:0] cache_data;
  logic        cache_ready;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        miss_err;
  logic [31:0] perf_fetched;
  logic [31:0] perf_miss_cycles;
  logic        hit = 1'b0;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q [$];

  always #5 clk = ~clk;

  function automatic logic [31:0] model_inst(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign cache_data  = model_inst(cache_addr);
  assign cache_ready = hit;

  inst_fetch_stage #(
    .RESET_PC(32'h0000_0000),
    .BUF_DEPTH(2),
    .MISS_TIMEOUT(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cache_addr(cache_addr),
    .cache_data(cache_data),
    .cache_ready(cache_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_inst(out_inst),
    .out_pc(out_pc),
    .miss_err(miss_err),
    .perf_fetched(perf_fetched),
    .perf_miss_cycles(perf_miss_cycles)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_pc(input logic [31:0] p);
    exp_q.push_back({model_inst(p), p});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_cache_addr", cache_addr, 32'h0);
    chk("rst_miss_err", {31'd0, miss_err}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted output beat is matched against the queue head.
  always @(negedge clk) begin
    logic [63:0] e;
    if (reset && out_valid && out_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got pc %h expected no output", out_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", out_pc, e[31:0]);
        chk("sb_inst", out_inst, e[63:32]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state and continuous hits
    apply_reset();
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_perf_fetched", perf_fetched, 32'h0);
    chk("rst_perf_miss", perf_miss_cycles, 32'h0);
    hit = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) expect_pc(32'(4 * k));
    reset = 1'b1;
    chk("t1_addr_release", cache_addr, 32'h0);
    chk("t1_valid_before", {31'd0, out_valid}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t1_stream_valid", {31'd0, out_valid}, 32'd1);
      chk("t1_stream_pc", out_pc, 32'(4 * k));
    end
    hit = 1'b0;
    repeat (3) tick();

    // Single miss at pc 8
    apply_reset();
    hit = 1'b1;
    out_ready = 1'b1;
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
    reset = 1'b1;
    tick(); tick();
    chk("t2_addr_pre_miss", cache_addr, 32'h8);
    hit = 1'b0;
    tick();
    chk("t2_addr_held", cache_addr, 32'h8);
    chk("t2_bubble", {31'd0, out_valid}, 32'd0);
    hit = 1'b1;
    tick();
    chk("t2_addr_resume", cache_addr, 32'hC);
    tick();
`ifdef FETCH_PERF_EN
    chk("t2_perf_miss", perf_miss_cycles, 32'd1);
    chk("t2_perf_fetched", perf_fetched, 32'd4);
`else
    chk("t2_perf_miss_tied", perf_miss_cycles, 32'd0);
    chk("t2_perf_fetched_tied", perf_fetched, 32'd0);
`endif
    hit = 1'b0;
    repeat (3) tick();

    // Backpressure then release
    apply_reset();
    hit = 1'b1;
    out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    chk("t3_stall_addr", cache_addr, 32'h8);
    chk("t3_full_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_full_head", out_pc, 32'h0);
    tick();
    chk("t3_stall_hold", cache_addr, 32'h8);
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
    out_ready = 1'b1;
    tick();
    chk("t3_resume_addr", cache_addr, 32'hC);
    chk("t3_resume_head", out_pc, 32'h4);
    hit = 1'b0;
    repeat (3) tick();

    // Redirect with a full FIFO and out_ready high
    apply_reset();
    hit = 1'b1;
    out_ready = 1'b0;
    reset = 1'b1;
    tick(); tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_1003;
    out_ready = 1'b1;
    expect_pc(32'h1000); expect_pc(32'h1004);
    tick();
    redirect_valid = 1'b0;
    chk("t4_flushed", {31'd0, out_valid}, 32'd0);
    chk("t4_redirect_addr", cache_addr, 32'h1000);
    tick();
    chk("t4_first_valid", {31'd0, out_valid}, 32'd1);
    chk("t4_first_pc", out_pc, 32'h1000);
    tick();
    hit = 1'b0;
    repeat (3) tick();

    // Miss timeout with MISS_TIMEOUT=4
    apply_reset();
    hit = 1'b0;
    out_ready = 1'b1;
    reset = 1'b1;
    repeat (3) tick();
    chk("t5_err_before", {31'd0, miss_err}, 32'd0);
    tick();
    chk("t5_err_set", {31'd0, miss_err}, 32'd1);
    hit = 1'b1;
    expect_pc(32'h0);
    tick();
    chk("t5_err_after_hit", {31'd0, miss_err}, 32'd1);
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_2000;
    hit = 1'b0;
    tick();
    redirect_valid = 1'b0;
    chk("t5_err_after_redirect", {31'd0, miss_err}, 32'd1);
    chk("t5_flushed", {31'd0, out_valid}, 32'd0);
    repeat (2) tick();

    // PC wrap
    apply_reset();
    hit = 1'b0;
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    reset = 1'b1;
    tick();
    redirect_valid = 1'b0;
    hit = 1'b1;
    chk("t6_addr_top", cache_addr, 32'hFFFF_FFFC);
    expect_pc(32'hFFFF_FFFC); expect_pc(32'h0);
    tick();
    chk("t6_addr_wrapped", cache_addr, 32'h0);
    tick();
    hit = 1'b0;
    repeat (3) tick();

    // Asynchronous reset during a miss
    apply_reset();
    hit = 1'b1;
    out_ready = 1'b0;
    reset = 1'b1;
    tick();
    hit = 1'b0;
    tick();
    chk("t7_valid_pre", {31'd0, out_valid}, 32'd1);
    chk("t7_addr_pre", cache_addr, 32'h4);
    #3 reset = 1'b0;
    #1;
    chk("t7_async_valid", {31'd0, out_valid}, 32'd0);
    chk("t7_async_addr", cache_addr, 32'h0);
    chk("t7_async_pc", out_pc, 32'h0);
    chk("t7_async_inst", out_inst, 32'h0);
    chk("t7_async_perf", perf_fetched, 32'h0);
    repeat (2) tick();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_stage.md
Name: inst_fetch_stage

Overview:
- Fetch stage directly downstream of the instruction cache; owns the PC and drives the cache lookup address.
- Captures each hit (instruction plus PC) into a small FIFO and presents it to decode over a valid/ready handshake.
- Holds the PC across cache misses while the cache fills, flushes on branch redirects, and flags a miss that never resolves.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset; bits [1:0] must be 0.
- BUF_DEPTH, 2, output FIFO entries; power of 2, minimum 2.
- MISS_TIMEOUT, 255, consecutive miss cycles before miss_err sets; range 1..65535.

Ports:
- clk  in  1  clock, posedge.
- reset  in  1  asynchronous, active-low.
- cache_addr  out  32  lookup address to cache; always equals the pc register.
- cache_data  in  32  cache read data; valid only when cache_ready=1.
- cache_ready  in  1  cache hit for cache_addr; combinational from cache_addr.
- redirect_valid  in  1  branch/jump redirect request.
- redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 0.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  decode accepts head entry.
- out_inst  out  32  head instruction.
- out_pc  out  32  PC of head instruction.
- miss_err  out  1  sticky miss-timeout flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_PC; FIFO empty; out_valid=0; out_inst=0; out_pc=0.
  - state=FETCH; miss counter=0; miss_err=0.
  - FIFO storage is cleared to 0.
  - Takes effect mid-operation at once; any in-flight miss or FIFO contents are discarded.
- Handshake signals:
  - pop = out_valid & out_ready.
  - space = FIFO not full, or pop.
  - Simultaneous push and pop on a full FIFO is allowed, so there is a combinational path from out_ready to the push decision.
- Push on a posedge when: no redirect, state != STALL or space has become true, cache_ready=1 and space=1.
  - Pushed entry is {cache_data, pc}.
  - pc <= pc+4, wrapping 32'hFFFF_FFFC to 0.
- Latency: an instruction that hits is visible on out_* the cycle after the posedge that pushed it. An empty FIFO with a continuous hit stream sustains 1 instruction per cycle.
- States (evaluated each posedge when redirect_valid=0):
  - FETCH:
    - cache_ready=1 with space: push and stay in FETCH.
    - cache_ready=0: go to MISS, miss counter <= 1.
    - cache_ready=1 without space: go to STALL.
  - MISS: pc held, no push.
    - cache_ready=1 with space: push, go to FETCH, counter <= 0.
    - cache_ready=1 without space: go to STALL, counter <= 0.
    - cache_ready=0: counter increments, saturating at MISS_TIMEOUT. When counter equals MISS_TIMEOUT, miss_err <= 1.
  - STALL: pc held, no push.
    - space=1: behave as FETCH this cycle (push on hit, or go to MISS on a miss).
- Redirect has priority over everything except reset:
  - pc <= {redirect_pc[31:2], 2'b00}; FIFO flushed (empty next cycle).
  - The same-cycle push and the same-cycle pop are both suppressed.
  - state <= FETCH; counter <= 0.
  - miss_err is unaffected.
- Cache behaviour: the cache fills on negedge, so a miss normally resolves with cache_ready=1 one cycle later. The stage must tolerate any number of miss cycles.
- miss_err is cleared only by reset.
- Pointers: FIFO read/write pointers wrap modulo BUF_DEPTH; an extra occupancy bit distinguishes full from empty.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: two extra output ports.
  - perf_fetched (32): count of pushes.
  - perf_miss_cycles (32): count of posedges spent in MISS.
  - Both zero on reset, wrap at 2^32, not cleared by redirect.
- Undefined: both ports are still present and tied to 32'h0; no counter logic is synthesized.

Test Plan:
- Reset then continuous hits, out_ready=1:
  - cache_addr=0 at reset release.
  - Outputs pc 0,4,8,… one per cycle.
  - First out_valid one cycle after the first posedge.
- Single miss at pc=8 (cache_ready=0 for 1 cycle):
  - cache_addr holds 8 for 2 cycles; state visits MISS.
  - out_pc sequence 0,4,8,12 with one bubble.
  - With FETCH_PERF_EN: perf_miss_cycles=1.
- Backpressure with out_ready=0, BUF_DEPTH=2:
  - Exactly 2 entries accepted; pc stalls at 8; state=STALL.
  - Raise out_ready: the push resumes in the same cycle as the first pop, with no lost or duplicated pc.
- Redirect to 32'h0000_1003 while the FIFO holds 2 entries and out_ready=1:
  - No pop that cycle; FIFO empty next cycle.
  - cache_addr=32'h0000_1000; next out_pc=32'h0000_1000.
- cache_ready held 0 with MISS_TIMEOUT=4:
  - miss_err rises on the 4th consecutive miss posedge.
  - miss_err stays 1 after hits resume and after a redirect; cleared only by reset.
- PC wrap: redirect to 32'hFFFF_FFFC with hits → out_pc 32'hFFFF_FFFC then 32'h0000_0000.
- Async reset asserted mid-MISS:
  - out_valid=0 and cache_addr=RESET_PC immediately, without waiting for a clock edge.
